// File: rtl/tube_scroller.sv
// -----------------------------------------------------------------------------
// tube_scroller
//
// Scrolls tube columns right-to-left across a COLS x 16 LED playfield. New
// columns enter at column COLS-1; each accepted tick shifts the field one
// column left. Tubes are TUBE_W columns wide (all carrying the pattern sampled
// on the tube's first column) and are separated by GAP blank columns. The field
// freezes while the bird is dead.
//
// Ports:
//   clk          system clock
//   RST          asynchronous active-low reset, clears all state
//   tick         single-cycle scroll strobe
//   dead         bird dead: freezes scrolling and suppresses score
//   pattern      candidate tube column (1 = lit tube pixel, 0 = opening)
//   bird_pos     one-hot bird row at column BIRD_COL
//   grid         playfield, column c at bits [16c+15:16c]
//   collide      registered overlap of bird_pos with grid column BIRD_COL
//   score_pulse  one-cycle pulse when column BIRD_COL goes from lit to blank
// -----------------------------------------------------------------------------
module tube_scroller #(
   parameter int COLS     = 16,
   parameter int TUBE_W   = 2,
   parameter int GAP      = 3,
   parameter int BIRD_COL = 2
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic                 tick,
   input  logic                 dead,
   input  logic [15:0]          pattern,
   input  logic [15:0]          bird_pos,
   output logic [16*COLS-1:0]   grid,
   output logic                 collide,
   output logic                 score_pulse
);

   localparam int MAX_CNT = (GAP > TUBE_W) ? GAP : TUBE_W;
   // Keep the counter at least one bit wide when GAP == TUBE_W == 1.
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [0:0] SPACE = 1'b0;
   localparam logic [0:0] TUBE  = 1'b1;

   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] TUBE_LAST = CNT_W'(TUBE_W - 1);

   logic [0:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [15:0]         hold_q, hold_d;
   logic [16*COLS-1:0]  grid_q, grid_d;
   logic                collide_q, collide_d;
   logic                score_q, score_d;
   logic [15:0]         entry;
   logic                accept;

   // dead dominates: a tick while dead is dropped, not deferred.
   assign accept = tick & ~dead;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      grid_d  = grid_q;
      entry   = 16'h0000;
      score_d = 1'b0;

      if (accept) begin
         case (state_q)
            SPACE: begin
               if (cnt_q == GAP_LAST) begin
                  state_d = TUBE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               // First tube column samples the picker; the rest replay it so
               // the whole tube shares one opening.
               if (cnt_q == '0) begin
                  entry  = pattern;
                  hold_d = pattern;
               end else begin
                  entry = hold_q;
               end
               if (cnt_q == TUBE_LAST) begin
                  state_d = SPACE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         endcase

         grid_d = {entry, grid_q[16*COLS-1:16]};

         // A lit column leaving BIRD_COL for a blank one marks a cleared tube;
         // all-zero tubes never light the column and so never score.
         score_d = (|grid_q[16*BIRD_COL +: 16]) & ~(|grid_d[16*BIRD_COL +: 16]);
      end
   end

   // Uses the registered grid, so collide trails the visible field by a cycle.
   assign collide_d = |(grid_q[16*BIRD_COL +: 16] & bird_pos);

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q   <= SPACE;
         cnt_q     <= '0;
         hold_q    <= 16'h0000;
         grid_q    <= '0;
         collide_q <= 1'b0;
         score_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         grid_q    <= grid_d;
         collide_q <= collide_d;
         score_q   <= score_d;
      end
   end

   assign grid        = grid_q;
   assign collide     = collide_q;
   assign score_pulse = score_q;

endmodule

// File: tb/tb_tube_scroller.sv
module tb_tube_scroller;

   localparam int COLS     = 16;
   localparam int TUBE_W   = 2;
   localparam int GAP      = 3;
   localparam int BIRD_COL = 2;
   localparam int GW       = 16 * COLS;

   logic            clk;
   logic            RST;
   logic            tick;
   logic            dead;
   logic [15:0]     pattern;
   logic [15:0]     bird_pos;
   logic [GW-1:0]   grid;
   logic            collide;
   logic            score_pulse;

   tube_scroller #(
      .COLS     (COLS),
      .TUBE_W   (TUBE_W),
      .GAP      (GAP),
      .BIRD_COL (BIRD_COL)
   ) dut (
      .clk         (clk),
      .RST         (RST),
      .tick        (tick),
      .dead        (dead),
      .pattern     (pattern),
      .bird_pos    (bird_pos),
      .grid        (grid),
      .collide     (collide),
      .score_pulse (score_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: entry column chosen from the accepted-tick count since
   // reset (phase within the tube period), not from a state machine.
   logic [15:0] m_grid [COLS];
   logic [15:0] m_hold;
   int          m_n;

   typedef struct {
      logic [GW-1:0] grid;
      logic          sc;
      logic          col;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic        t;
      logic        d;
      logic [15:0] p;
      logic [15:0] b;
      logic [15:0] c15;
      logic [15:0] c2;
      logic        sc;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [GW-1:0] act, input logic [GW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [GW-1:0] m_flat();
      logic [GW-1:0] v;
      for (int c = 0; c < COLS; c++) v[16*c +: 16] = m_grid[c];
      return v;
   endfunction

   task automatic m_clear();
      for (int c = 0; c < COLS; c++) m_grid[c] = 16'h0000;
      m_hold = 16'h0000;
      m_n    = 0;
   endtask

   // One clock: drive inputs, predict, push; after the edge, pop and compare.
   task automatic cycle(input logic t, input logic d, input logic [15:0] p, input logic [15:0] b);
      exp_t        e;
      exp_t        g;
      logic [15:0] entry;
      logic [15:0] old2;
      int          ph;
      tick     = t;
      dead     = d;
      pattern  = p;
      bird_pos = b;
      e.col = |(m_grid[BIRD_COL] & b);
      e.sc  = 1'b0;
      old2  = m_grid[BIRD_COL];
      if (t && !d) begin
         m_n++;
         ph = (m_n - 1) % (GAP + TUBE_W);
         if (ph < GAP) entry = 16'h0000;
         else if (ph == GAP) begin
            entry  = p;
            m_hold = p;
         end else entry = m_hold;
         for (int c = 0; c < COLS - 1; c++) m_grid[c] = m_grid[c+1];
         m_grid[COLS-1] = entry;
         e.sc = (old2 != 16'h0000) && (m_grid[BIRD_COL] == 16'h0000);
      end
      e.grid = m_flat();
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         g = sb.pop_front();
         chk("sb_grid", grid, g.grid);
         chk("sb_score", GW'(score_pulse), GW'(g.sc));
         chk("sb_collide", GW'(collide), GW'(g.col));
      end
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
   task automatic do_reset();
      #3;
      RST = 1'b0;
      #1;
      chk("rst_async_grid", grid, '0);
      chk("rst_async_collide", GW'(collide), '0);
      chk("rst_async_score", GW'(score_pulse), '0);
      tick = 1'b0;
      dead = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_held_grid", grid, '0);
      RST = 1'b1;
      m_clear();
   endtask

   task automatic add(input logic t, input logic [15:0] p, input logic [15:0] b,
                      input logic [15:0] c15, input logic [15:0] c2, input logic sc);
      vec_t v;
      v.t = t; v.d = 1'b0; v.p = p; v.b = b; v.c15 = c15; v.c2 = c2; v.sc = sc;
      tbl.push_back(v);
   endtask

   logic [GW-1:0] snap;
   int            pulses;

   initial begin
      // Entry and score sequence: tick numbers in comments.
      add(1, 16'h1FFF, 16'h0000, 16'h0000, 16'h0000, 0); // 1
      add(1, 16'h1FFF, 16'h0000, 16'h0000, 16'h0000, 0); // 2
      add(1, 16'h1FFF, 16'h0000, 16'h0000, 16'h0000, 0); // 3
      add(1, 16'h1FFF, 16'h0000, 16'h1FFF, 16'h0000, 0); // 4
      add(0, 16'hC7FF, 16'h0000, 16'h1FFF, 16'h0000, 0); // idle
      add(1, 16'hC7FF, 16'h0000, 16'h1FFF, 16'h0000, 0); // 5
      add(1, 16'hC7FF, 16'h0000, 16'h0000, 16'h0000, 0); // 6
      add(1, 16'hC7FF, 16'h0000, 16'h0000, 16'h0000, 0); // 7
      add(1, 16'hC7FF, 16'h0000, 16'h0000, 16'h0000, 0); // 8
      add(1, 16'hC7FF, 16'h0000, 16'hC7FF, 16'h0000, 0); // 9
      add(1, 16'hC7FF, 16'h0000, 16'hC7FF, 16'h0000, 0); // 10
      add(1, 16'hC7FF, 16'h0000, 16'h0000, 16'h0000, 0); // 11
      add(1, 16'hC7FF, 16'h0000, 16'h0000, 16'h0000, 0); // 12
      add(1, 16'hC7FF, 16'h0000, 16'h0000, 16'h0000, 0); // 13
      add(1, 16'hC7FF, 16'h0000, 16'hC7FF, 16'h0000, 0); // 14
      add(1, 16'hC7FF, 16'h0000, 16'hC7FF, 16'h0000, 0); // 15
      add(1, 16'hC7FF, 16'h0001, 16'h0000, 16'h0000, 0); // 16
      add(1, 16'hC7FF, 16'h0001, 16'h0000, 16'h1FFF, 0); // 17
      add(1, 16'hC7FF, 16'h0001, 16'h0000, 16'h1FFF, 0); // 18
      add(1, 16'hC7FF, 16'h0001, 16'hC7FF, 16'h0000, 1); // 19
      add(0, 16'hC7FF, 16'h0001, 16'hC7FF, 16'h0000, 0); // idle
      add(1, 16'hC7FF, 16'h0000, 16'hC7FF, 16'h0000, 0); // 20
      add(1, 16'hC7FF, 16'h0000, 16'h0000, 16'h0000, 0); // 21

      RST = 1'b0; tick = 1'b0; dead = 1'b0; pattern = 16'h0; bird_pos = 16'h0;
      m_clear();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_grid", grid, '0);
      chk("reset_collide", GW'(collide), '0);
      chk("reset_score", GW'(score_pulse), '0);
      RST = 1'b1;

      // Table-driven entry and score run.
      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].t, tbl[i].d, tbl[i].p, tbl[i].b);
         chk($sformatf("tbl%0d_c15", i), GW'(grid[16*(COLS-1) +: 16]), GW'(tbl[i].c15));
         chk($sformatf("tbl%0d_c2", i), GW'(grid[16*BIRD_COL +: 16]), GW'(tbl[i].c2));
         chk($sformatf("tbl%0d_score", i), GW'(score_pulse), GW'(tbl[i].sc));
      end

      // Freeze: dead with tick held high leaves the field untouched.
      snap = m_flat();
      for (int i = 0; i < 5; i++) begin
         cycle(1, 1, 16'hFFFF, 16'h0000);
         chk("freeze_grid", grid, snap);
         chk("freeze_score", GW'(score_pulse), '0);
      end
      cycle(1, 0, 16'hC7FF, 16'h0000);                              // 22
      chk("unfreeze_shift", grid, {16'h0000, snap[GW-1:16]});
      cycle(1, 0, 16'hC7FF, 16'h0000);                              // 23
      cycle(1, 0, 16'h3333, 16'h0000);                              // 24, tube starts

      // Reset mid-tube: partial tube and hold are discarded.
      do_reset();
      for (int n = 1; n <= 5; n++) begin
         cycle(1, 0, (n == 4) ? 16'h00FF : 16'h5555, 16'h0000);
         if (n <= 3) chk("post_rst_space", GW'(grid[16*(COLS-1) +: 16]), '0);
         else chk("post_rst_tube", GW'(grid[16*(COLS-1) +: 16]), GW'(16'h00FF));
      end

      // Collision at BIRD_COL.
      do_reset();
      for (int n = 1; n <= 17; n++) cycle(1, 0, 16'h1FFF, 16'h0000);
      chk("col_setup", GW'(grid[16*BIRD_COL +: 16]), GW'(16'h1FFF));
      cycle(0, 0, 16'h1FFF, 16'h0001);
      chk("collide_hit", GW'(collide), GW'(1'b1));
      cycle(0, 0, 16'h1FFF, 16'h2000);
      chk("collide_gap", GW'(collide), '0);
      cycle(1, 0, 16'h1FFF, 16'h0001);                              // 18
      cycle(1, 0, 16'h1FFF, 16'h0001);                              // 19, col2 blank
      chk("collide_lag", GW'(collide), GW'(1'b1));
      cycle(0, 0, 16'h1FFF, 16'h0001);
      chk("collide_blank", GW'(collide), '0);

      // Zero-pattern tube is invisible and never scores; the next one does.
      do_reset();
      pulses = 0;
      for (int n = 1; n <= 25; n++) begin
         cycle(1, 0, (n <= 8) ? 16'h0000 : 16'h1FFF, 16'h0000);
         if (n <= 8) chk("zero_grid", grid, '0);
         chk($sformatf("zero_score_t%0d", n), GW'(score_pulse), GW'(n == 24));
         if (score_pulse) pulses++;
      end
      chk("zero_pulse_count", GW'(pulses), GW'(1));
      chk("sb_drained", GW'(sb.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
